// File: rtl/stream_mux_pkg.sv
// Shared constants, arbitration state and pointer helper for stream_mux_rr.
// Packet locking is enabled with STREAM_MUX_LOCK_EN.
package stream_mux_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  typedef enum logic {ARB, LOCK} state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping; combinational.
// No state and no backpressure; the caller qualifies the grant.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt_oh,
  output logic [SELW-1:0] gnt_idx
);

  localparam int SW1 = SELW + 1;

  logic [SW1-1:0]  pos;
  logic [SELW-1:0] idx;

  // Scan farthest-first so the nearest requester after ptr overwrites the rest.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    pos     = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + SW1'(k);
      if (pos >= SW1'(N)) pos = pos - SW1'(N);
      idx = pos[SELW-1:0];
      if (req[idx]) begin
        gnt_oh      = '0;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 round-robin stream mux with a one-entry output register; 1-cycle latency.
// Stalled output blocks all in_ready; STREAM_MUX_LOCK_EN adds packet-atomic grants.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N    = N_DEF,
  parameter  int W    = W_DEF,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [N-1:0]    in_last,
  output logic            out_last,
`endif
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_sel
);

  logic            load;
  logic            xfer;
  logic            ptr_upd;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] arb_idx;
  logic [SELW-1:0] gnt_idx;
  logic [N-1:0]    arb_oh;
  logic [N-1:0]    gnt_oh;
  logic [W-1:0]    ch_data [N];

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch_data[i] = in_data[i*W +: W];
  end

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx)
  );

  assign load     = !out_valid || out_ready;
  assign in_ready = (load && (|in_valid) && !rst) ? gnt_oh : '0;
  assign xfer     = |(in_valid & in_ready);

`ifdef STREAM_MUX_LOCK_EN
  state_e          state;
  state_e          state_nxt;
  logic [SELW-1:0] lock_ch;

  // While locked the grant stays on lock_ch even if it is idle.
  always_comb begin
    gnt_oh  = arb_oh;
    gnt_idx = arb_idx;
    if (state == LOCK) begin
      gnt_oh          = '0;
      gnt_oh[lock_ch] = 1'b1;
      gnt_idx         = lock_ch;
    end
  end

  always_comb begin
    state_nxt = state;
    if (xfer) state_nxt = in_last[gnt_idx] ? ARB : LOCK;
  end

  assign ptr_upd = xfer && ((state == ARB) || in_last[gnt_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      lock_ch  <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer && state == ARB) lock_ch <= gnt_idx;
      if (xfer) out_last <= in_last[gnt_idx];
    end
  end
`else
  assign gnt_oh  = arb_oh;
  assign gnt_idx = arb_idx;
  assign ptr_upd = xfer;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[gnt_idx];
        out_sel   <= gnt_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (ptr_upd) ptr <= SELW'(rr_next(32'(gnt_idx), N));
    end
  end

endmodule
